// File: rtl/fpa_add_slice_sequencer.sv
// ---------------------------------------------------------------------------
// fpa_add_slice_sequencer
//
// Purpose:
//   Multi-cycle wide adder controller. Takes W-bit operands over a
//   valid/ready handshake, feeds them one N-bit slice per cycle (LSB slice
//   first) to an external combinational slice adder, chains the carry using
//   the returned group propagate/generate, and presents the reassembled W-bit
//   sum on a valid/ready output.
//
// Optional feature (macro FPA_ADD_SEQ_EARLY_ACCEPT_EN):
//   Defined   : in DONE, in_ready follows out_ready so a new operation can be
//               accepted on the same edge as the output handshake
//               (one op per K+1 cycles).
//   Undefined : in_ready is low in DONE; an IDLE cycle separates operations
//               (one op per K+2 cycles).
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake
//   in_a, in_b, in_ci     W-bit operands and carry into slice 0
//   slice_a/b/ci          current slice driven to the external slice adder
//   slice_c/cp/cg         slice sum, group propagate, group generate
//   out_valid/out_ready   result handshake
//   out_sum/co/ovf        W-bit sum, MSB carry out, signed overflow
// ---------------------------------------------------------------------------
module fpa_add_slice_sequencer #(
  parameter int W = 32,
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_ci,
  output logic [N-1:0] slice_a,
  output logic [N-1:0] slice_b,
  output logic         slice_ci,
  input  logic [N-1:0] slice_c,
  input  logic         slice_cp,
  input  logic         slice_cg,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_co,
  output logic         out_ovf
);

  localparam int K  = W / N;
  localparam int IW = (K > 1) ? $clog2(K) : 1;

  generate
    if ((N < 1) || (W < N) || ((W % N) != 0)) begin : g_bad_width
      $error("fpa_add_slice_sequencer: W must be a positive multiple of N");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [IW-1:0]   r_idx;
  logic            r_carry;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic [W-1:0]    r_sum;
  logic            w_ready;
  logic            w_accept;
  logic            w_last;
  logic [N-1:0]    w_a_sl [K];
  logic [N-1:0]    w_b_sl [K];

  // Slice views of the registered operands, selected by the beat index.
  generate
    for (genvar gi = 0; gi < K; gi++) begin : g_slice
      assign w_a_sl[gi] = r_a[gi*N +: N];
      assign w_b_sl[gi] = r_b[gi*N +: N];
    end
  endgenerate

  assign w_last   = (r_idx == IW'(K - 1));
  // in_ready is held low for as long as rst is asserted.
  assign in_ready = w_ready & ~rst;
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_ready      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_ready = 1'b1;
        if (in_valid) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
`ifdef FPA_ADD_SEQ_EARLY_ACCEPT_EN
        w_ready = out_ready;
        if (out_ready) begin
          w_state_next = in_valid ? S_RUN : S_IDLE;
        end
`else
        if (out_ready) begin
          w_state_next = S_IDLE;
        end
`endif
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
    end else if (w_accept) begin
      r_a     <= in_a;
      r_b     <= in_b;
      r_carry <= in_ci;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      for (int k = 0; k < K; k++) begin
        if (r_idx == IW'(k)) begin
          r_sum[k*N +: N] <= slice_c;
        end
      end
      // Carry into the next slice from the group propagate/generate terms.
      r_carry <= slice_cg | (slice_cp & r_carry);
      if (!w_last) begin
        r_idx <= r_idx + IW'(1);
      end
    end
  end

  always_comb begin
    slice_a  = '0;
    slice_b  = '0;
    slice_ci = 1'b0;
    if (r_state == S_RUN) begin
      slice_a  = w_a_sl[r_idx];
      slice_b  = w_b_sl[r_idx];
      slice_ci = r_carry;
    end
  end

  assign out_valid = (r_state == S_DONE);
  assign out_sum   = r_sum;
  assign out_co    = out_valid & r_carry;
  // Overflow: operands share a sign and the result sign differs from it.
  assign out_ovf   = out_valid & (r_a[W-1] == r_b[W-1]) & (r_sum[W-1] != r_a[W-1]);

endmodule

// File: doc/fpa_add_slice_sequencer.md
Name: fpa_add_slice_sequencer

Overview:
Multi-cycle wide adder controller for the FixedPointArithmetic Add unit. It accepts W-bit operands over a valid/ready handshake and splits them into N-bit slices. Each slice is driven into an external combinational N-bit slice adder, one slice per cycle, LSB slice first. The returned slice sum and group propagate/generate are consumed to chain the carry, and the W-bit result is reassembled and presented on a valid/ready output.

Parameters:
W, 32, total operand width; must be an integer multiple of N (elaboration error otherwise)
N, 8, slice width presented to the external slice adder
K (localparam), W/N, number of slices (beats) per operation

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand bundle valid
in_ready  output  1  block can accept operands
in_a  input  W  operand A
in_b  input  W  operand B
in_ci  input  1  carry in to slice 0
slice_a  output  N  current slice of A to slice adder
slice_b  output  N  current slice of B to slice adder
slice_ci  output  1  chained carry into current slice
slice_c  input  N  slice sum returned (combinational, same cycle)
slice_cp  input  1  slice group propagate
slice_cg  input  1  slice group generate
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
out_sum  output  W  assembled sum
out_co  output  1  carry out of MSB slice
out_ovf  output  1  signed two's-complement overflow

Behaviour:
- Reset is asynchronous, active-high. On rst:
  - state=IDLE, beat index=0, carry register=0, operand and result registers=0.
  - out_valid=0, out_sum=0, out_co=0, out_ovf=0.
  - in_ready is forced 0 while rst is high and rises to 1 the first cycle after release.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register in_a, in_b; carry<=in_ci; idx<=0; go to RUN.
- RUN:
  - in_ready=0; in_valid is ignored.
  - slice_a/slice_b = registered operand bits [idx*N +: N]; slice_ci = carry register.
  - Each clock: result[idx*N +: N]<=slice_c; carry<=slice_cg | (slice_cp & carry).
  - If idx==K-1, go to DONE; else idx<=idx+1.
- DONE:
  - out_valid=1.
  - out_co = final carry.
  - out_ovf = (a[W-1]==b[W-1]) && (out_sum[W-1]!=a[W-1]), computed from registered operands.
  - On out_valid&out_ready, go to IDLE.
- Slice outputs when not in RUN: slice_a=0, slice_b=0, slice_ci=0.
- Latency: accept on edge E0. out_valid is high after edge E_K, i.e. K cycles after acceptance (4 for defaults). Throughput is one operation per K+2 cycles without the optional feature.
- Backpressure: out_sum, out_co and out_ovf are held stable while out_valid&!out_ready, indefinitely.
- Input rule: upstream must hold in_a/in_b/in_ci stable while in_valid&!in_ready; the block samples them only at the accept edge.
- K=1: RUN lasts one cycle; behaviour is otherwise identical.
- Reset mid-RUN or mid-DONE: the operation is discarded, no out_valid pulse, and the block is back in IDLE after release.
- Carry arithmetic is modulo 2^W; the carry out of the MSB slice appears only on out_co.

Optional Feature:
Macro FPA_ADD_SEQ_EARLY_ACCEPT_EN.
- Defined:
  - In DONE, in_ready = out_ready.
  - A simultaneous output handshake and input accept goes directly DONE->RUN with the new operands, giving back-to-back throughput of one op per K+1 cycles.
- Undefined:
  - in_ready=0 in DONE; at least one IDLE cycle separates operations.

Test Plan:
- Carry ripple: W=32, N=8, A=0xFFFFFFFF, B=0x00000001, ci=0 -> out_sum=0x00000000, out_co=1, out_ovf=0; out_valid rises exactly 4 cycles after accept; slice_ci observed as 0,1,1,1 over the beats.
- Signed overflow: A=0x7FFFFFFF, B=0x00000001, ci=0 -> out_sum=0x80000000, out_co=0, out_ovf=1. Also A=0x80000000, B=0x80000000 -> sum=0x00000000, co=1, ovf=1.
- Carry in: A=0x12345678, B=0x00000000, ci=1 -> out_sum=0x12345679, co=0, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, no second accept. Then out_ready=1 -> state IDLE the next cycle.
- Reset mid-RUN: assert rst asynchronously during beat 2 of an operation -> out_valid=0 immediately and no result emitted. After release, in_ready=1; the next op 0x00000010+0x00000020 returns 0x00000030.
- Back-to-back: continuous in_valid with out_ready=1.
  - With FPA_ADD_SEQ_EARLY_ACCEPT_EN: second accept coincides with the first output handshake, giving a 5-cycle accept interval.
  - Without it: the accept interval is 6 cycles.
